bus_arbiter: RTL

Central round-robin arbiter for the shared multi-master bus. It takes the active-low per-CPU request lines and drives the matching active-low grant lines. It watches FRAME_B/IRDY_B so the grant is held while the owner's transaction is in flight. It sits directly upstream of every bus master, and the masters use its GNT_B outputs to gain bus ownership.

---
 rtl/bus_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter for the shared multi-master bus. Takes the
//               active-low request lines, drives one-cold active-low grants,
//               and holds the grant while FRAME_B/IRDY_B show a transaction
//               in flight. Revokes an unused grant after TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int NUM_MASTERS = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_b,
    input  logic                   frame_b,
    input  logic                   irdy_b,
    output logic [NUM_MASTERS-1:0] gnt_b,
    output logic [2:0]             owner,
    output logic                   owner_valid,
    output logic                   timeout_evt
);

    localparam int c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GRANT = 2'd1;
    localparam logic [1:0] c_BUSY  = 2'd2;
    localparam logic [1:0] c_TURN  = 2'd3;

    logic [1:0]             r_state;
    logic [NUM_MASTERS-1:0] r_gnt_b;
    logic [2:0]             r_owner;
    logic                   r_owner_valid;
    logic                   r_timeout_evt;
    logic [2:0]             r_last;
    logic [c_CNT_W-1:0]     r_cnt;

    logic                   w_any;
    logic [2:0]             w_sel;
    logic [NUM_MASTERS-1:0] w_sel_oh;
    logic                   w_owner_req;

    // Round-robin pick: scan last+1, last+2, ... (mod NUM_MASTERS) for the
    // first active-low request; the first hit stops further matches.
    always_comb begin
        w_any    = 1'b0;
        w_sel    = 3'd0;
        w_sel_oh = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!w_any && (i == ((int'(r_last) + k) % NUM_MASTERS)) && !req_b[i]) begin
                    w_any       = 1'b1;
                    w_sel       = 3'(i);
                    w_sel_oh[i] = 1'b1;
                end
            end
        end
    end

    // Request line of the current owner (reads as idle for nonexistent indices).
    always_comb begin
        w_owner_req = 1'b1;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_owner == 3'(i)) begin
                w_owner_req = req_b[i];
            end
        end
    end

    // Arbitration state machine with registered grant/owner/timeout outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_gnt_b       <= '1;
            r_owner       <= 3'd0;
            r_owner_valid <= 1'b0;
            r_timeout_evt <= 1'b0;
            r_last        <= 3'(NUM_MASTERS - 1);
            r_cnt         <= '0;
        end else begin
            r_timeout_evt <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_gnt_b       <= ~w_sel_oh;
                        r_owner       <= w_sel;
                        r_owner_valid <= 1'b1;
                        r_last        <= w_sel;
                        r_cnt         <= '0;
                        r_state       <= c_GRANT;
                    end
                end
                c_GRANT: begin
                    // Frame start beats withdrawal and timeout on the same edge.
                    if (!frame_b) begin
                        r_state <= c_BUSY;
                    end else if (w_owner_req) begin
                        r_gnt_b       <= '1;
                        r_owner_valid <= 1'b0;
                        r_state       <= c_TURN;
                    end else if (r_cnt == c_TMO_LAST) begin
                        r_gnt_b       <= '1;
                        r_owner_valid <= 1'b0;
                        r_timeout_evt <= 1'b1;
                        r_state       <= c_TURN;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_BUSY: begin
                    if (frame_b && irdy_b) begin
                        r_gnt_b       <= '1;
                        r_owner_valid <= 1'b0;
                        r_state       <= c_TURN;
                    end
                end
                c_TURN: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign gnt_b       = r_gnt_b;
    assign owner       = r_owner;
    assign owner_valid = r_owner_valid;
    assign timeout_evt = r_timeout_evt;

endmodule
`default_nettype wire
